// File: rtl/ptcalc_sched.sv
// ptcalc_sched -- round-robin scheduler sharing one HLS pT-calculation core
// among N_THR station-fit threads.
//
// Each thread owns a one-deep slot holding a complete candidate (pipeline
// word, inner/middle/outer segment words, C-side flag). An idle FSM grants
// the next full slot after the last-served thread, copies it into operand
// registers held constant for the whole job, and drives the core's
// ap_start/ap_ready/ap_done handshake. A captured result is emitted one
// cycle later tagged with the thread index. A job that stays in START+WAIT
// for TIMEOUT cycles is dropped and the core is reset for two cycles.
//
// Ports:
//   ap_clk, ap_rst_n           clock, synchronous active-low reset
//   req_valid/req_ready        per-thread slot handshake (ready = slot empty)
//   req_pl, req_sf_inn/mid/out per-thread candidate fields, thread i at [i*W +: W]
//   req_is_c                   per-thread C-side flag
//   core_start/ready/done      core ap_start / ap_ready / ap_done
//   core_rst                   core reset, active-high
//   core_pl, core_sf_*, core_is_c  operands held for the running job
//   core_res, core_res_vld     core result
//   res_data/res_valid/res_thr registered result, one-cycle strobe, thread tag
//   busy                       FSM not idle
//   nores_cnt, timeout_cnt     saturating event counters
module ptcalc_sched #(
  parameter int unsigned N_THR   = 3,
  parameter int unsigned PL_W    = 16,
  parameter int unsigned SF_W    = 16,
  parameter int unsigned MTC_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic [N_THR-1:0]        req_valid,
  output logic [N_THR-1:0]        req_ready,
  input  logic [N_THR*PL_W-1:0]   req_pl,
  input  logic [N_THR*SF_W-1:0]   req_sf_inn,
  input  logic [N_THR*SF_W-1:0]   req_sf_mid,
  input  logic [N_THR*SF_W-1:0]   req_sf_out,
  input  logic [N_THR-1:0]        req_is_c,
  output logic                    core_start,
  input  logic                    core_ready,
  input  logic                    core_done,
  output logic                    core_rst,
  output logic [PL_W-1:0]         core_pl,
  output logic [SF_W-1:0]         core_sf_inn,
  output logic [SF_W-1:0]         core_sf_mid,
  output logic [SF_W-1:0]         core_sf_out,
  output logic                    core_is_c,
  input  logic [MTC_W-1:0]        core_res,
  input  logic                    core_res_vld,
  output logic [MTC_W-1:0]        res_data,
  output logic                    res_valid,
  output logic [2:0]              res_thr,
  output logic                    busy,
  output logic [7:0]              nores_cnt,
  output logic [7:0]              timeout_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_FLUSH} state_t;

  state_t state, state_nxt;

  logic [N_THR-1:0] full;
  logic [PL_W-1:0]  slot_pl  [N_THR];
  logic [SF_W-1:0]  slot_inn [N_THR];
  logic [SF_W-1:0]  slot_mid [N_THR];
  logic [SF_W-1:0]  slot_out [N_THR];
  logic [N_THR-1:0] slot_is_c;

  logic [2:0] rr;
  logic [2:0] thr;
  logic [2:0] gnt;
  logic [2:0] gnt_hi;
  logic [2:0] gnt_lo;
  logic       hi_found;
  logic       grant_en;
  logic       got;
  logic [7:0] tcnt;
  logic       tmo;
  logic       abort;
  logic       fl_cnt;

  assign req_ready = ~full;

  // Round-robin pick: the lowest full slot above rr wins; otherwise wrap to
  // the lowest full slot at or below rr. Descending loops leave the lowest
  // matching index as the final assignment.
  always_comb begin
    gnt_hi   = '0;
    gnt_lo   = '0;
    hi_found = 1'b0;
    for (int unsigned i = N_THR; i >= 1; i--) begin
      if (full[i-1]) begin
        if ((i - 1) > 32'(rr)) begin
          gnt_hi   = 3'(i - 1);
          hi_found = 1'b1;
        end else begin
          gnt_lo = 3'(i - 1);
        end
      end
    end
    gnt = hi_found ? gnt_hi : gnt_lo;
  end

  assign grant_en = (state == S_IDLE) && (|full);
  assign tmo      = (tcnt == 8'(TIMEOUT - 1));
  // A done arriving on the last allowed cycle still completes the job.
  assign abort    = ((state == S_START) && tmo) ||
                    ((state == S_WAIT) && tmo && !core_done);

  // Slot buffers: accept only into empty slots, clear on grant.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      full      <= '0;
      slot_is_c <= '0;
      for (int unsigned i = 0; i < N_THR; i++) begin
        slot_pl[i]  <= '0;
        slot_inn[i] <= '0;
        slot_mid[i] <= '0;
        slot_out[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_THR; i++) begin
        if (req_valid[i] && !full[i]) begin
          full[i]      <= 1'b1;
          slot_pl[i]   <= req_pl[i*PL_W +: PL_W];
          slot_inn[i]  <= req_sf_inn[i*SF_W +: SF_W];
          slot_mid[i]  <= req_sf_mid[i*SF_W +: SF_W];
          slot_out[i]  <= req_sf_out[i*SF_W +: SF_W];
          slot_is_c[i] <= req_is_c[i];
        end else if (grant_en && (32'(gnt) == i)) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|full) state_nxt = S_START;
      S_START: begin
        if (abort)           state_nxt = S_FLUSH;
        else if (core_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (core_done)  state_nxt = S_IDLE;
        else if (abort) state_nxt = S_FLUSH;
      end
      S_FLUSH: if (fl_cnt) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    core_start = (state == S_START);
    busy       = (state != S_IDLE);
    core_rst   = !ap_rst_n || (state == S_FLUSH);
  end

  // Operands, job bookkeeping, result capture and counters
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      rr          <= 3'(N_THR - 1);
      thr         <= '0;
      got         <= 1'b0;
      tcnt        <= '0;
      fl_cnt      <= 1'b0;
      core_pl     <= '0;
      core_sf_inn <= '0;
      core_sf_mid <= '0;
      core_sf_out <= '0;
      core_is_c   <= 1'b0;
      res_data    <= '0;
      res_valid   <= 1'b0;
      nores_cnt   <= '0;
      timeout_cnt <= '0;
    end else begin
      res_valid <= 1'b0;
      fl_cnt    <= (state == S_FLUSH);

      if (grant_en) begin
        core_pl     <= slot_pl[gnt];
        core_sf_inn <= slot_inn[gnt];
        core_sf_mid <= slot_mid[gnt];
        core_sf_out <= slot_out[gnt];
        core_is_c   <= slot_is_c[gnt];
        rr          <= gnt;
        thr         <= gnt;
        got         <= 1'b0;
        tcnt        <= '0;
      end

      if ((state == S_START) || (state == S_WAIT))
        tcnt <= tcnt + 8'd1;

      // Only the first result of a job is emitted; a dropped job emits none.
      if ((state == S_WAIT) && core_res_vld && !got && !abort) begin
        res_data  <= core_res;
        res_valid <= 1'b1;
        got       <= 1'b1;
      end

      if ((state == S_WAIT) && core_done && !got && !core_res_vld &&
          (nores_cnt != 8'hFF))
        nores_cnt <= nores_cnt + 8'd1;

      if (abort && (timeout_cnt != 8'hFF))
        timeout_cnt <= timeout_cnt + 8'd1;
    end
  end

  assign res_thr = thr;

endmodule

// File: tb/tb_ptcalc_sched.sv
module tb_ptcalc_sched;

  localparam int unsigned N_THR = 3;
  localparam int unsigned W     = 16;

  logic            clk = 1'b0;
  logic            ap_rst_n;
  logic [2:0]      req_valid;
  logic [2:0]      req_ready;
  logic [3*W-1:0]  req_pl, req_sf_inn, req_sf_mid, req_sf_out;
  logic [2:0]      req_is_c;
  logic            core_start, core_ready, core_done, core_rst;
  logic [W-1:0]    core_pl, core_sf_inn, core_sf_mid, core_sf_out;
  logic            core_is_c;
  logic [W-1:0]    core_res;
  logic            core_res_vld;
  logic [W-1:0]    res_data;
  logic            res_valid;
  logic [2:0]      res_thr;
  logic            busy;
  logic [7:0]      nores_cnt, timeout_cnt;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [18:0] q[$];

  ptcalc_sched #(
    .N_THR(N_THR), .PL_W(W), .SF_W(W), .MTC_W(W), .TIMEOUT(255)
  ) dut (
    .ap_clk(clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_pl(req_pl), .req_sf_inn(req_sf_inn), .req_sf_mid(req_sf_mid),
    .req_sf_out(req_sf_out), .req_is_c(req_is_c),
    .core_start(core_start), .core_ready(core_ready), .core_done(core_done),
    .core_rst(core_rst), .core_pl(core_pl), .core_sf_inn(core_sf_inn),
    .core_sf_mid(core_sf_mid), .core_sf_out(core_sf_out), .core_is_c(core_is_c),
    .core_res(core_res), .core_res_vld(core_res_vld),
    .res_data(res_data), .res_valid(res_valid), .res_thr(res_thr),
    .busy(busy), .nores_cnt(nores_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every res_valid strobe must match the oldest pending result.
  task automatic mon();
    logic [18:0] e;
    if (res_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("res_valid_unexpected", res_valid, 0);
      end else begin
        e = q.pop_front();
        chk("res_data", res_data, e[15:0]);
        chk("res_thr", res_thr, e[18:16]);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
  endtask

  function automatic logic [W-1:0] sf_i(input logic [W-1:0] pl); return pl ^ 16'h1111; endfunction
  function automatic logic [W-1:0] sf_m(input logic [W-1:0] pl); return pl ^ 16'h2222; endfunction
  function automatic logic [W-1:0] sf_o(input logic [W-1:0] pl); return pl ^ 16'h3333; endfunction

  task automatic set_slot(input int unsigned i, input logic [W-1:0] pl);
    req_pl[i*W +: W]     = pl;
    req_sf_inn[i*W +: W] = sf_i(pl);
    req_sf_mid[i*W +: W] = sf_m(pl);
    req_sf_out[i*W +: W] = sf_o(pl);
    req_is_c[i]          = pl[0];
  endtask

  task automatic submit(input int unsigned i, input logic [W-1:0] pl);
    set_slot(i, pl);
    req_valid[i] = 1'b1;
    cyc();
    req_valid[i] = 1'b0;
    chk("submit_accepted", req_ready[i], 0);
  endtask

  task automatic chk_ops(input string tag, input logic [W-1:0] pl);
    chk({tag, "_pl"}, core_pl, pl);
    chk({tag, "_sf_inn"}, core_sf_inn, sf_i(pl));
    chk({tag, "_sf_mid"}, core_sf_mid, sf_m(pl));
    chk({tag, "_sf_out"}, core_sf_out, sf_o(pl));
    chk({tag, "_is_c"}, core_is_c, pl[0]);
  endtask

  // Core model for one job: ready on first START cycle, done lat cycles later.
  task automatic serve(input int unsigned thr, input logic [W-1:0] pl,
                       input logic [W-1:0] res, input int unsigned lat,
                       input bit give_res);
    int unsigned w;
    logic [2:0] t3;
    w  = 0;
    t3 = 3'(thr);
    while (core_start !== 1'b1 && w < 50) begin
      cyc();
      w++;
    end
    chk("serve_start_seen", core_start, 1);
    chk_ops("serve_op", pl);
    core_ready = 1'b1;
    cyc();
    core_ready = 1'b0;
    chk("serve_start_dropped", core_start, 0);
    repeat (lat - 1) cyc();
    core_res     = res;
    core_res_vld = give_res;
    core_done    = 1'b1;
    if (give_res) q.push_back({t3, res});
    cyc();
    core_res_vld = 1'b0;
    core_done    = 1'b0;
    chk("serve_idle_after_done", busy, 0);
  endtask

  initial begin
    logic [63:0] snap;
    int unsigned n;

    ap_rst_n     = 1'b0;
    req_valid    = '0;
    req_pl       = '0;
    req_sf_inn   = '0;
    req_sf_mid   = '0;
    req_sf_out   = '0;
    req_is_c     = '0;
    core_ready   = 1'b0;
    core_done    = 1'b0;
    core_res     = '0;
    core_res_vld = 1'b0;

    // Reset state
    repeat (3) cyc();
    chk("rst_core_rst", core_rst, 1);
    chk("rst_req_ready", req_ready, 3'b111);
    chk("rst_busy", busy, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_pl", core_pl, 0);
    chk("rst_res_valid", res_valid, 0);
    ap_rst_n = 1'b1;
    cyc();
    chk("post_rst_core_rst", core_rst, 0);
    chk("post_rst_counters", {nores_cnt, timeout_cnt}, 0);

    // Single job on thread 1
    submit(1, 16'h00A5);
    chk("single_ready_mask", req_ready, 3'b101);
    chk("single_start_not_yet", core_start, 0);
    cyc();
    chk("single_start_t2", core_start, 1);
    chk("single_busy", busy, 1);
    chk("single_slot_freed", req_ready, 3'b111);
    chk_ops("single_op", 16'h00A5);
    core_ready = 1'b1;
    cyc();
    core_ready = 1'b0;
    chk("single_start_one_cycle", core_start, 0);
    repeat (9) cyc();
    core_res     = 16'h0123;
    core_res_vld = 1'b1;
    core_done    = 1'b1;
    q.push_back({3'd1, 16'h0123});
    cyc();
    core_res_vld = 1'b0;
    core_done    = 1'b0;
    chk("single_res_valid", res_valid, 1);
    chk("single_busy_done", busy, 0);
    cyc();
    chk("single_res_valid_pulse", res_valid, 0);

    // No-result job
    submit(0, 16'h0C00);
    serve(0, 16'h0C00, 16'h0000, 3, 1'b0);
    chk("nores_cnt", nores_cnt, 1);
    cyc();
    chk("nores_no_strobe", res_valid, 0);

    // Handshake hold: core_ready low 4 cycles, thread 2 arrives meanwhile
    submit(0, 16'h0B01);
    cyc();
    chk("hold_start_c0", core_start, 1);
    snap = {core_pl, core_sf_inn, core_sf_mid, core_sf_out};
    chk_ops("hold_op", 16'h0B01);
    set_slot(2, 16'h2C02);
    req_valid[2] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      req_valid[2] = 1'b0;
      chk("hold_start_high", core_start, 1);
      chk("hold_ops_stable", {core_pl, core_sf_inn, core_sf_mid, core_sf_out}, snap);
      chk("hold_slot2_pending", req_ready[2], 0);
    end
    core_ready = 1'b1;
    cyc();
    core_ready = 1'b0;
    chk("hold_start_released", core_start, 0);
    chk("hold_ops_wait", core_pl, 16'h0B01);
    repeat (2) cyc();
    core_res     = 16'h0B0B;
    core_res_vld = 1'b1;
    core_done    = 1'b1;
    q.push_back({3'd0, 16'h0B0B});
    cyc();
    core_res_vld = 1'b0;
    core_done    = 1'b0;
    serve(2, 16'h2C02, 16'h2222, 4, 1'b1);

    // Second res_vld within one job is ignored
    submit(1, 16'h1E01);
    serve(1, 16'h1E01, 16'h1111, 2, 1'b1);
    chk("dup_busy", busy, 0);
    cyc();
    chk("dup_no_second_strobe", res_valid, 0);

    // Timeout: core never ready, thread 0 pending meanwhile
    submit(1, 16'h1D01);
    cyc();
    set_slot(0, 16'h0D00);
    req_valid[0] = 1'b1;
    n = 0;
    while (core_start === 1'b1 && n < 300) begin
      n++;
      cyc();
      req_valid[0] = 1'b0;
    end
    chk("timeout_start_cycles", n, 255);
    chk("timeout_flush1_rst", core_rst, 1);
    chk("timeout_cnt", timeout_cnt, 1);
    chk("timeout_pending_kept", req_ready[0], 0);
    cyc();
    chk("timeout_flush2_rst", core_rst, 1);
    cyc();
    chk("timeout_flush_end", core_rst, 0);
    chk("timeout_idle", busy, 0);
    serve(0, 16'h0D00, 16'h0DDD, 3, 1'b1);
    chk("counters_before_reset", {nores_cnt, timeout_cnt}, 16'h0101);

    // Reset mid-WAIT
    submit(2, 16'h2E02);
    cyc();
    chk("rstmid_start", core_start, 1);
    core_ready = 1'b1;
    cyc();
    core_ready = 1'b0;
    submit(0, 16'h0E00);
    chk("rstmid_in_wait", {busy, core_start}, 2'b10);
    ap_rst_n     = 1'b0;
    core_res     = 16'hBAD0;
    core_res_vld = 1'b1;
    #1;
    chk("rstmid_core_rst_now", core_rst, 1);
    cyc();
    core_res_vld = 1'b0;
    chk("rstmid_req_ready", req_ready, 3'b111);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_counters", {nores_cnt, timeout_cnt}, 0);
    chk("rstmid_core_rst", core_rst, 1);
    chk("rstmid_res_valid", res_valid, 0);
    ap_rst_n = 1'b1;
    cyc();
    chk("rstmid_released", core_rst, 0);
    cyc();
    chk("rstmid_idle", busy, 0);
    chk("rstmid_no_strobe", res_valid, 0);

    // Fairness: all threads valid continuously, 5-cycle core latency
    for (int unsigned i = 0; i < N_THR; i++) set_slot(i, 16'h0A00 | 16'(i << 12) | 16'(i));
    req_valid = 3'b111;
    for (int unsigned j = 0; j < 6; j++) begin
      serve(j % 3, 16'h0A00 | 16'((j % 3) << 12) | 16'(j % 3), 16'h5000 + 16'(j), 5, 1'b1);
      chk("fair_refilled", req_ready, 3'b000);
    end
    req_valid = '0;
    for (int unsigned j = 0; j < 3; j++)
      serve(j, 16'h0A00 | 16'(j << 12) | 16'(j), 16'h6000 + 16'(j), 5, 1'b1);
    cyc();
    chk("fair_drained", req_ready, 3'b111);
    chk("fair_idle", busy, 0);
    chk("sb_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
